mc_ctrl_v2: RTL and testbench
=============================

Name: mc_ctrl_v2

Overview:
- Parametrised multi-cycle MIPS control unit; successor to the first-generation `ctr` controller.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK across the datapath (PC, IR, GPR, ALU, EXT, NPC, DM).
- Adds three things the first generation lacks:
  - optional ready/wait handshake on instruction and data memory;
  - illegal-instruction detection;
  - retired-instruction counter.
- Sits between the IR fields and the datapath select/enable inputs.

Parameters:
- ALU_OP_W, 2, width of ALUOp (encodings 0 add, 1 sub, 2 or; higher codes reserved).
- MEM_WAIT, 0, 1 = honour im_rdy/dm_rdy; 0 = treat both as constant 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  6  IR[31:26]
- fun  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- im_rdy  in  1  instruction memory data valid
- dm_rdy  in  1  data memory read data valid / write accepted
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- DMWr  out  1  data memory write enable
- GPRWr  out  1  register file write enable
- BSel  out  1  ALU B operand: 0 = rt, 1 = EXT output
- WDSel  out  2  GPR write data: 00 ALU, 01 DM, 10 PC
- GPRSel  out  2  GPR write address: 00 rd, 01 rt, 10 $31
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- NPCOp  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 jr (rs)
- ALUOp  out  ALU_OP_W  ALU operation
- ill  out  1  one-cycle pulse on an undecodable instruction
- retired  out  CNT_W  count of completed instructions
- state  out  4  current FSM state (debug)

Behaviour:
- Supported instructions:
  - R-type (op 000000): addu (fun 100001), subu (fun 100011), jr (fun 001000).
  - Others: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encodings: S0 FETCH, S1 DCD, S2 MA, S3 MR, S4 MWB, S5 MW, S6 EXE, S7 ALUWB, S8 BR, S9 JMP.
- Outputs are decoded combinationally from the registered state and op/fun. IR is stable after FETCH. Any output not listed for a state is 0.
- Reset:
  - rst high on a rising edge sets state to FETCH and retired to 0.
  - While rst is high, PCWr/IRWr/DMWr/GPRWr are forced to 0 and ill is 0.
  - Reset mid-instruction abandons the instruction; it is not counted.
- FETCH:
  - Asserts IRWr=1, PCWr=1, NPCOp=00.
  - With MEM_WAIT=1 and im_rdy=0, IRWr and PCWr are 0 and the FSM stays in FETCH.
  - Otherwise next state is DCD.
- DCD: no write enables. Next state by instruction:
  - lw/sw → MA
  - addu/subu/ori/lui → EXE
  - beq → BR
  - j/jal/jr → JMP
  - anything else: ill=1 for this cycle, next FETCH; instruction treated as a NOP and not counted.
- MA:
  - ALUOp=add, BSel=1, ExtOp=01.
  - Next state MR (lw) or MW (sw).
- MR:
  - Holds MA's ALU controls.
  - Waits while MEM_WAIT && !dm_rdy.
  - Otherwise next state MWB.
- MWB:
  - GPRWr=1, GPRSel=01, WDSel=01.
  - Retire; next state FETCH.
- MW:
  - DMWr=1, with MA's ALU controls held.
  - DMWr stays high while MEM_WAIT && !dm_rdy; the FSM holds.
  - Once accepted: retire, next state FETCH.
- EXE: ALU controls by instruction:
  - addu: ALUOp=add, BSel=0.
  - subu: ALUOp=sub, BSel=0.
  - ori: ALUOp=or, BSel=1, ExtOp=00.
  - lui: ALUOp=or, BSel=1, ExtOp=10. Datapath supplies rs=$0 for lui.
  - Next state ALUWB.
- ALUWB:
  - Holds EXE controls.
  - GPRWr=1, WDSel=00, GPRSel=00 for R-type, 01 otherwise.
  - Retire; next state FETCH.
- BR:
  - ALUOp=sub, BSel=0, NPCOp=01, ExtOp=01, PCWr=Zero.
  - Retire; next state FETCH.
- JMP:
  - PCWr=1; NPCOp=11 for jr, 10 for j/jal.
  - jal also asserts GPRWr=1, GPRSel=10, WDSel=10. PC already holds PC+4 at this point.
  - Retire; next state FETCH.
- Retirement counter:
  - "Retire" increments retired on the state-exit edge.
  - retired wraps modulo 2^CNT_W; no saturation.
- Write-enable constraints:
  - At most one of PCWr/GPRWr/DMWr is asserted in any state, except JMP for jal (PCWr and GPRWr together).
  - DMWr is never asserted outside MW.
- Unreachable state encodings (10–15) recover to FETCH on the next edge with no writes.

Decomposition:
- Shared package mc_pkg:
  - opcode and funct localparams;
  - state encodings S0–S9;
  - WDSel/GPRSel/ExtOp/NPCOp/ALUOp encodings.
- One natural sub-module, mc_decode: combinational op/fun → instruction-class one-hot plus ill_dec.
- The FSM, output decode and counter remain in mc_ctrl_v2.

Test Plan:
- Reset, then MEM_WAIT=0, addu (op 0, fun 100001): states 0,1,6,7,0; GPRWr=1 only in S7 with GPRSel=00, WDSel=00; retired 0→1.
- lw with MEM_WAIT=1, dm_rdy low for 3 cycles: S3 held 3 extra cycles; GPRWr=1 in S4 with WDSel=01, GPRSel=01; total 8 cycles; retired +1.
- sw with MEM_WAIT=1, dm_rdy low for 2 cycles: DMWr=1 for exactly 3 consecutive cycles in S5; no GPRWr; then FETCH.
- beq with Zero=1, then beq with Zero=0: PCWr=1 with NPCOp=01 in S8 for the first, PCWr=0 for the second; each takes 3 cycles; retired +2.
- jal then jr (op 0, fun 001000): jal gives S9 with PCWr=1, NPCOp=10, GPRWr=1, GPRSel=10, WDSel=10; jr gives NPCOp=11, GPRWr=0.
- Illegal op 111111: ill=1 for one cycle in S1, next FETCH, retired unchanged. Then rst asserted during S3 of an lw: state=0 next edge, retired=0, no GPRWr.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared opcode, funct, state and select encodings for the multi-cycle controller
package mc_pkg;
  localparam logic [5:0] OP_RT  = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [3:0] S0_FETCH = 4'd0;
  localparam logic [3:0] S1_DCD   = 4'd1;
  localparam logic [3:0] S2_MA    = 4'd2;
  localparam logic [3:0] S3_MR    = 4'd3;
  localparam logic [3:0] S4_MWB   = 4'd4;
  localparam logic [3:0] S5_MW    = 4'd5;
  localparam logic [3:0] S6_EXE   = 4'd6;
  localparam logic [3:0] S7_ALUWB = 4'd7;
  localparam logic [3:0] S8_BR    = 4'd8;
  localparam logic [3:0] S9_JMP   = 4'd9;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;
  localparam logic [1:0] GS_RD = 2'd0;
  localparam logic [1:0] GS_RT = 2'd1;
  localparam logic [1:0] GS_RA = 2'd2;
  localparam logic [1:0] EXT_ZE  = 2'd0;
  localparam logic [1:0] EXT_SE  = 2'd1;
  localparam logic [1:0] EXT_LUI = 2'd2;
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  typedef struct packed {
    logic addu, subu, jr, ori, lui, lw, sw, beq, j, jal;
  } cls_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: op/fun to one-hot instruction class, flagging anything undecodable
import mc_pkg::*;
module mc_decode (
  input  logic [5:0] op_i,
  input  logic [5:0] fun_i,
  output cls_t       cls_o,
  output logic       ill_o
);
  always_comb begin
    cls_o.addu = op_i == OP_RT && fun_i == FN_ADDU;
    cls_o.subu = op_i == OP_RT && fun_i == FN_SUBU;
    cls_o.jr   = op_i == OP_RT && fun_i == FN_JR;
    cls_o.ori  = op_i == OP_ORI;
    cls_o.lui  = op_i == OP_LUI;
    cls_o.lw   = op_i == OP_LW;
    cls_o.sw   = op_i == OP_SW;
    cls_o.beq  = op_i == OP_BEQ;
    cls_o.j    = op_i == OP_J;
    cls_o.jal  = op_i == OP_JAL;
    ill_o      = ~|cls_o;
  end
endmodule

// File: rtl/mc_ctrl_v2.sv
// mc_ctrl_v2: multi-cycle MIPS control FSM with memory handshake, illegal-op pulse and retire counter
import mc_pkg::*;
module mc_ctrl_v2 #(
  parameter int ALU_OP_W = 2,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          fun,
  input  logic                Zero,
  input  logic                im_rdy,
  input  logic                dm_rdy,
  output logic                PCWr,
  output logic                IRWr,
  output logic                DMWr,
  output logic                GPRWr,
  output logic                BSel,
  output logic [1:0]          WDSel,
  output logic [1:0]          GPRSel,
  output logic [1:0]          ExtOp,
  output logic [1:0]          NPCOp,
  output logic [ALU_OP_W-1:0] ALUOp,
  output logic                ill,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state
);
  logic [3:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] alu;
  logic pc_we, ir_we, dm_we, gpr_we, ill_p, ret, ill_dec, im_ok, dm_ok;
  cls_t c;
  mc_decode u_dec (.op_i(op), .fun_i(fun), .cls_o(c), .ill_o(ill_dec));
  assign im_ok = MEM_WAIT == 0 || im_rdy;
  assign dm_ok = MEM_WAIT == 0 || dm_rdy;
  always_comb begin
    {pc_we, ir_we, dm_we, gpr_we, ill_p, BSel, ret} = '0;
    WDSel = WD_ALU;
    GPRSel = GS_RD;
    ExtOp = EXT_ZE;
    NPCOp = NPC_PC4;
    alu = ALU_ADD;
    state_d = S0_FETCH;
    case (state_q)
      S0_FETCH: begin
        pc_we = im_ok;
        ir_we = im_ok;
        state_d = im_ok ? S1_DCD : S0_FETCH;
      end
      S1_DCD: begin
        ill_p = ill_dec;
        state_d = (c.lw | c.sw) ? S2_MA :
                  (c.addu | c.subu | c.ori | c.lui) ? S6_EXE :
                  c.beq ? S8_BR :
                  (c.j | c.jal | c.jr) ? S9_JMP : S0_FETCH;
      end
      S2_MA, S3_MR, S5_MW: begin
        BSel = 1'b1;
        ExtOp = EXT_SE;
        dm_we = state_q == S5_MW;
        ret = state_q == S5_MW && dm_ok;
        state_d = state_q == S2_MA ? (c.lw ? S3_MR : S5_MW) :
                  state_q == S3_MR ? (dm_ok ? S4_MWB : S3_MR) :
                  (dm_ok ? S0_FETCH : S5_MW);
      end
      S4_MWB: begin
        gpr_we = 1'b1;
        GPRSel = GS_RT;
        WDSel = WD_DM;
        ret = 1'b1;
      end
      S6_EXE, S7_ALUWB: begin
        alu = c.subu ? ALU_SUB : (c.ori | c.lui) ? ALU_OR : ALU_ADD;
        BSel = c.ori | c.lui;
        ExtOp = c.lui ? EXT_LUI : EXT_ZE;
        gpr_we = state_q == S7_ALUWB;
        GPRSel = (state_q == S7_ALUWB && (c.ori | c.lui)) ? GS_RT : GS_RD;
        ret = state_q == S7_ALUWB;
        state_d = state_q == S6_EXE ? S7_ALUWB : S0_FETCH;
      end
      S8_BR: begin
        alu = ALU_SUB;
        NPCOp = NPC_BR;
        ExtOp = EXT_SE;
        pc_we = Zero;
        ret = 1'b1;
      end
      S9_JMP: begin
        pc_we = 1'b1;
        NPCOp = c.jr ? NPC_JR : NPC_J;
        gpr_we = c.jal;
        GPRSel = c.jal ? GS_RA : GS_RD;
        WDSel = c.jal ? WD_PC : WD_ALU;
        ret = 1'b1;
      end
      default: ;
    endcase
  end
  assign PCWr = pc_we & ~rst;
  assign IRWr = ir_we & ~rst;
  assign DMWr = dm_we & ~rst;
  assign GPRWr = gpr_we & ~rst;
  assign ill = ill_p & ~rst;
  assign ALUOp = ALU_OP_W'(alu);
  assign retired = cnt_q;
  assign state = state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0_FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + CNT_W'(ret);
    end
  end
endmodule

// File: tb/tb_mc_ctrl_v2.sv
// tb_mc_ctrl_v2: random instruction stream checked against a per-instruction phase table model
module tb_mc_ctrl_v2;
  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, im_rdy = 1'b1, dm_rdy = 1'b1;
  logic [5:0] op = '0, fun = '0;
  logic PCWr, IRWr, DMWr, GPRWr, BSel, ill;
  logic [1:0] WDSel, GPRSel, ExtOp, NPCOp, ALUOp;
  logic [3:0] retired, state;
  int nvec = 0, nerr = 0, exp_ret = 0;
  typedef struct {
    logic [3:0] st;
    logic [15:0] ctl;
    int wt;
    bit zpc;
    bit ret;
  } ph_t;
  ph_t q[$];
  always #5 clk = ~clk;
  mc_ctrl_v2 #(.ALU_OP_W(2), .MEM_WAIT(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .fun(fun), .Zero(Zero), .im_rdy(im_rdy), .dm_rdy(dm_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .DMWr(DMWr), .GPRWr(GPRWr), .BSel(BSel), .WDSel(WDSel),
    .GPRSel(GPRSel), .ExtOp(ExtOp), .NPCOp(NPCOp), .ALUOp(ALUOp), .ill(ill),
    .retired(retired), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] c16(bit pc, bit ir, bit dm, bit gw, bit bs, int wd, int gs, int ex, int np, int al, bit il);
    return {pc, ir, dm, gw, bs, 2'(wd), 2'(gs), 2'(ex), 2'(np), 2'(al), il};
  endfunction
  function automatic ph_t mk(int st, logic [15:0] ctl, int wt, bit zpc, bit ret);
    ph_t p;
    p.st = 4'(st);
    p.ctl = ctl;
    p.wt = wt;
    p.zpc = zpc;
    p.ret = ret;
    return p;
  endfunction
  // kinds: 0 addu 1 subu 2 jr 3 ori 4 lui 5 lw 6 sw 7 beq 8 j 9 jal 10 illegal
  task automatic build(input int k);
    logic [15:0] ma;
    ma = c16(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    q.push_back(mk(0, c16(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0));
    q.push_back(mk(1, c16(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k == 10), 0, 0, 0));
    case (k)
      0, 1, 3, 4: begin
        q.push_back(mk(6, c16(0, 0, 0, 0, k >= 3, 0, 0, k == 4 ? 2 : 0, 0, k == 1 ? 1 : k >= 3 ? 2 : 0, 0), 0, 0, 0));
        q.push_back(mk(7, c16(0, 0, 0, 1, k >= 3, 0, k >= 3, k == 4 ? 2 : 0, 0, k == 1 ? 1 : k >= 3 ? 2 : 0, 0), 0, 0, 1));
      end
      5: begin
        q.push_back(mk(2, ma, 0, 0, 0));
        q.push_back(mk(3, ma, 2, 0, 0));
        q.push_back(mk(4, c16(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), 0, 0, 1));
      end
      6: begin
        q.push_back(mk(2, ma, 0, 0, 0));
        q.push_back(mk(5, ma | 16'h2000, 2, 0, 1));
      end
      7: q.push_back(mk(8, c16(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 0, 1, 1));
      2, 8, 9: q.push_back(mk(9, c16(1, 0, 0, k == 9, 0, k == 9 ? 2 : 0, k == 9 ? 2 : 0, 0, k == 2 ? 3 : 2, 0, 0), 0, 0, 1));
      default: ;
    endcase
  endtask
  initial begin
    logic [5:0] ops[10], funs[10];
    logic [15:0] e;
    ph_t h;
    int k, r;
    ops = '{6'h00, 6'h00, 6'h00, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    funs = '{6'b100001, 6'b100011, 6'b001000, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0};
    repeat (2) @(posedge clk);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        k = $urandom_range(10);
        if (k < 10) begin
          op = ops[k];
          fun = k < 3 ? funs[k] : 6'($urandom);
        end else begin
          r = $urandom_range(2);
          op = r == 0 ? 6'b111111 : r == 1 ? 6'b001000 : 6'b000000;
          fun = r == 2 ? 6'b100000 : 6'($urandom);
        end
        build(k);
      end
      Zero = 1'($urandom);
      im_rdy = $urandom_range(3) != 0;
      dm_rdy = $urandom_range(2) != 0;
      rst = $urandom_range(149) == 0;
      #1;
      h = q[0];
      e = h.ctl;
      if (h.zpc) e[15] = Zero;
      if (h.wt == 1) e[15:14] = e[15:14] & {2{im_rdy}};
      if (rst) e = e & 16'h0FFE;
      chk("state", 32'(state), 32'(h.st));
      chk("retired", 32'(retired), exp_ret);
      chk("controls", 32'({PCWr, IRWr, DMWr, GPRWr, BSel, WDSel, GPRSel, ExtOp, NPCOp, ALUOp, ill}), 32'(e));
      if (rst) begin
        q.delete();
        exp_ret = 0;
      end else if (h.wt == 0 || (h.wt == 1 && im_rdy) || (h.wt == 2 && dm_rdy)) begin
        if (h.ret) exp_ret = (exp_ret + 1) % 16;
        void'(q.pop_front());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
